// File: rtl/act_pkg.sv
// Shared definitions for the activation pipeline: mode encodings used by the
// lane datapath and the pipeline top.
package act_pkg;

  typedef enum logic [1:0] {
    ACT_BYPASS = 2'd0,
    ACT_RELU   = 2'd1,
    ACT_LEAKY  = 2'd2,
    ACT_CLIP   = 2'd3
  } act_mode_e;

  localparam int MODE_W = 2;

endpackage

// File: rtl/act_lane.sv
// Combinational activation for one signed lane; also flags whether the
// activation changed the value, which feeds the clamp event counter.
module act_lane
  import act_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int LEAK_SHIFT = 3
) (
  input  logic signed [DATA_W-1:0] din,
  input  act_mode_e                mode,
  input  logic signed [DATA_W-1:0] clip_max,
  output logic signed [DATA_W-1:0] dout,
  output logic                     altered
);

  logic din_neg;
  logic clip_neg;

  assign din_neg  = din[DATA_W-1];
  assign clip_neg = clip_max[DATA_W-1];

  always_comb begin
    dout = din;
    case (mode)
      ACT_BYPASS: dout = din;
      ACT_RELU: begin
        if (din_neg) dout = '0;
      end
      ACT_LEAKY: begin
        // arithmetic shift floors toward -inf, so -1 stays -1
        if (din_neg) dout = din >>> LEAK_SHIFT;
      end
      ACT_CLIP: begin
        if (din_neg || clip_neg) dout = '0;
        else if (din > clip_max) dout = clip_max;
      end
      default: dout = din;
    endcase
    altered = (dout != din);
  end

endmodule

// File: rtl/activation_pipe.sv
// Two-stage valid/ready activation pipeline (S1 compute, S2 output) across
// CHANNELS lanes, with a saturating count of lanes altered by the activation.
module activation_pipe
  import act_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int CHANNELS   = 4,
  parameter int LEAK_SHIFT = 3,
  parameter int CNT_W      = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_W*CHANNELS-1:0]   in_data,
  input  logic                         in_last,
  input  logic [MODE_W-1:0]            mode,
  input  logic [DATA_W-1:0]            clip_max,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_W*CHANNELS-1:0]   out_data,
  output logic                         out_last,
  output logic [CNT_W-1:0]             clamp_count,
  input  logic                         count_clear
);

  localparam int BUS_W = DATA_W * CHANNELS;
  localparam int AW    = $clog2(CHANNELS + 1);
  localparam int SW    = ((CNT_W > AW) ? CNT_W : AW) + 1;

  logic [BUS_W-1:0]    lane_res;
  logic [CHANNELS-1:0] lane_alt;

  logic                s1_valid;
  logic [BUS_W-1:0]    s1_data;
  logic                s1_last;

  logic                s2_load;
  logic                accept;
  logic [AW-1:0]       alt_cnt;
  logic [SW-1:0]       cnt_sum;
  logic [CNT_W-1:0]    cnt_next;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    act_lane #(
      .DATA_W     (DATA_W),
      .LEAK_SHIFT (LEAK_SHIFT)
    ) u_lane (
      .din      (in_data[DATA_W*g +: DATA_W]),
      .mode     (act_mode_e'(mode)),
      .clip_max (clip_max),
      .dout     (lane_res[DATA_W*g +: DATA_W]),
      .altered  (lane_alt[g])
    );
  end

  // S1 advances exactly when S2 can take its contents
  assign s2_load  = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_load;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_last  <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_data <= lane_res;
        s1_last <= in_last;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= s1_data;
        out_last <= s1_last;
      end
    end
  end

  always_comb begin
    alt_cnt = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      alt_cnt = alt_cnt + AW'(lane_alt[i]);
    end
    cnt_sum  = SW'(clamp_count) + SW'(alt_cnt);
    cnt_next = (cnt_sum > SW'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      clamp_count <= '0;
    end else if (count_clear) begin
      clamp_count <= '0;
    end else if (accept) begin
      clamp_count <= cnt_next;
    end
  end

endmodule

// File: doc/activation_pipe.md
ACTIVATION_PIPE -- requirements
Module: activation_pipe

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning the signed two's-complement width of each channel.
REQ-002 The block SHALL have parameter CHANNELS, default 4, meaning the number of parallel activation lanes.
REQ-003 The block SHALL have parameter LEAK_SHIFT, default 3, meaning the arithmetic right shift applied to negative inputs in leaky mode.
REQ-004 The block SHALL have parameter CNT_W, default 16, meaning the width of the clamp event counter.
REQ-005 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-006 clock  input  1  rising-edge clock for all state.
REQ-007 reset  input  1  asynchronous, active-low reset; asserted when 0.
REQ-008 in_valid  input  1  input beat present.
REQ-009 in_ready  output  1  block accepts a beat this cycle.
REQ-010 in_data  input  DATA_W*CHANNELS  lane i at bits [DATA_W*i+DATA_W-1 : DATA_W*i].
REQ-011 in_last  input  1  end-of-frame marker, carried with the beat.
REQ-012 mode  input  2  activation select, sampled with each accepted beat.
REQ-013 clip_max  input  DATA_W  signed upper bound for clipped mode, sampled with each accepted beat.
REQ-014 out_valid  output  1  output beat present.
REQ-015 out_ready  input  1  downstream accepts the beat.
REQ-016 out_data  output  DATA_W*CHANNELS  results, same lane order as in_data.
REQ-017 out_last  output  1  in_last of the same beat.
REQ-018 clamp_count  output  CNT_W  saturating count of lanes altered by the activation.
REQ-019 count_clear  input  1  synchronous clear of clamp_count.

Function
REQ-020 mode 0 (BYPASS): out = in.
REQ-021 mode 1 (RELU): out = 0 if in < 0, else in.
REQ-022 mode 2 (LEAKY): out = in >>> LEAK_SHIFT (arithmetic, floor rounding) if in < 0, else in; e.g. DATA_W=8, shift 3: -1 -> -1, -9 -> -2, -128 -> -16.
REQ-023 mode 3 (CLIP): out = 0 if in < 0; clip_max if in > clip_max; else in; a negative clip_max yields 0 for every lane.
REQ-024 A beat SHALL transfer on a cycle where valid and ready are both high, on each side.
REQ-025 Pipeline SHALL be two register stages (S1 compute, S2 output); latency in_valid&in_ready to out_valid = 2 cycles when unstalled.
REQ-026 Throughput SHALL be one beat per cycle while out_ready is held high.
REQ-027 S2 SHALL load when empty or when out_ready is high; S1 SHALL advance under the same condition; in_ready = !S1_valid or S1 advancing.
REQ-028 out_data, out_last, out_valid SHALL hold stable while out_valid=1 and out_ready=0.
REQ-029 No beat SHALL be dropped, duplicated or reordered under any out_ready pattern.
REQ-030 A lane is "altered" when its output differs from its input; clamp_count SHALL add the number of altered lanes of each beat accepted into S1.
REQ-031 clamp_count SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-032 count_clear SHALL force clamp_count to 0 next cycle, taking priority over a simultaneous increment.

Reset
REQ-033 While reset=0: out_valid=0, S1/S2 valid=0, out_data=0, out_last=0, clamp_count=0; in_ready=1 from the first cycle after release.
REQ-034 Reset asserted mid-stream SHALL discard all in-flight beats with no partial output.

Structure
REQ-035 Mode encodings (BYPASS, RELU, LEAKY, CLIP) SHALL be constants in shared package act_pkg.
REQ-036 Per-lane arithmetic SHALL be a combinational sub-module act_lane (outputs result and altered flag), instantiated CHANNELS times.

Verification
REQ-037 RELU, DATA_W=8, CHANNELS=4, in {0x80,0xFF,0x00,0x7F}, out_ready=1 -> out {0x00,0x00,0x00,0x7F} two cycles later, clamp_count=2.
REQ-038 LEAKY, in {-9,-1,-128,5} -> out {-2,-1,-16,5}, clamp_count +=2 (-1 unaltered).
REQ-039 CLIP, clip_max=6, in {-3,3,6,100} -> {0,3,6,6}; clip_max=-1, in {5,..} -> all 0.
REQ-040 100 random beats, out_ready toggled randomly -> output sequence and out_last identical to model, data stable while stalled.
REQ-041 CNT_W=4, 5 beats of all-negative RELU -> clamp_count stops at 15; count_clear with concurrent increment -> 0.
REQ-042 reset pulsed low with both stages full -> out_valid=0 immediately, no stale beat after release.
